uart_alu_bridge: RTL
====================

Name: uart_alu_bridge

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte output, done strobe and parity-error flag.
- Assembles a three-byte command: operand A, operand B, opcode. Drives the registered operands and opcode to the combinational ALU.
- Hands the ALU result to the UART transmitter with a one-cycle start strobe, then waits for transmit completion before accepting the next command.

Parameters:
- DATA_BITS, 8, width of received bytes, operands and result.
- OP_BITS, 6, width of alu_op; taken from the low OP_BITS of the third received byte.
- ERR_CNT_BITS, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  DATA_BITS  received byte from the receiver (d_out).
- rx_done  input  1  receiver done flag; may stay high for more than one cycle.
- rx_error  input  1  receiver parity error; valid while rx_done is high.
- alu_result  input  DATA_BITS  combinational ALU output.
- tx_done  input  1  transmitter completion flag; level or pulse.
- alu_a  output  DATA_BITS  registered operand A.
- alu_b  output  DATA_BITS  registered operand B.
- alu_op  output  OP_BITS  registered opcode.
- tx_data  output  DATA_BITS  registered byte for the transmitter.
- tx_start  output  1  one-cycle transmit request.
- busy  output  1  high in SEND and WAIT_TX.
- overrun  output  1  sticky: a byte arrived while busy.
- err_count  output  ERR_CNT_BITS  count of rejected bytes, saturating at all-ones.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0. State goes to WAIT_A. Edge-detect registers go to 0.
  - Reset overrides every other event in the same cycle, including mid-command and mid-transmit.
- Edge detection:
  - rx_ev = rx_done & ~rx_done_q, where rx_done_q is rx_done registered.
  - tx_ev is formed the same way from tx_done.
  - A level held high counts once. Processing uses rx_ev in the same cycle, so a byte is registered one clock after rx_done rises.
- WAIT_A:
  - rx_ev & ~rx_error: alu_a <= rx_data; go to WAIT_B.
- WAIT_B:
  - rx_ev & ~rx_error: alu_b <= rx_data; go to WAIT_OP.
- WAIT_OP:
  - rx_ev & ~rx_error: alu_op <= rx_data[OP_BITS-1:0]; go to SEND.
  - Upper byte bits are ignored.
- Error in any WAIT_* state (rx_ev & rx_error):
  - Byte discarded; err_count increments (saturates at all-ones); go to WAIT_A.
  - alu_a, alu_b and alu_op keep their previous values.
- SEND (one cycle):
  - tx_data <= alu_result; tx_start <= 1; go to WAIT_TX.
  - The ALU has had one full cycle with stable operands before the capture.
- WAIT_TX:
  - tx_start returns to 0; it is high for exactly one cycle.
  - tx_ev: go to WAIT_A.
  - tx_done already high on entry produces no tx_ev and does not end the wait.
- Bytes arriving while busy:
  - rx_ev in SEND or WAIT_TX: byte dropped; overrun <= 1.
  - overrun is cleared only by reset.
- Simultaneous events:
  - rx_ev and tx_ev in the same WAIT_TX cycle: go to WAIT_A, drop the byte, set overrun.
- Latency: last rx_done rising edge to tx_start high is 2 cycles (edge cycle → opcode registered/SEND → tx_start registered).
- alu_a, alu_b and alu_op hold across commands until overwritten.
- busy = (state == SEND) | (state == WAIT_TX), registered-state decode.
- Illegal state encoding: go to WAIT_A on the next clock.

Test Plan:
- Reset, then rx_data 0x05, 0x03, 0x20 each with a 3-cycle rx_done, rx_error=0; stub alu_result=0x08 → alu_a=0x05, alu_b=0x03, alu_op=0x20. tx_data=0x08 with tx_start high exactly 1 cycle, 2 cycles after the third rx_done edge. busy=1 until tx_done pulse, then busy=0.
- Second byte 0x11 with rx_error=1 → err_count=1, state WAIT_A. Then 0xAA, 0x55, 0x24 clean → alu_a=0xAA, alu_b=0x55, alu_op=0x24; one tx_start.
- rx_done held high 10 cycles with rx_data=0x7F → only alu_a captured; state WAIT_B, no further advance.
- Byte 0x33 arrives while waiting for tx_done → overrun=1, tx_data unchanged. After tx_done the next command assembles normally; overrun stays 1.
- Reset asserted in WAIT_OP after two bytes → all outputs 0, err_count=0. A fresh 3-byte command completes correctly.
- 20 consecutive error bytes with ERR_CNT_BITS=4 → err_count saturates at 0xF.

Source files
------------

// File: rtl/uart_alu_bridge.sv
// Bridge between a UART receiver/transmitter pair and a combinational ALU:
// assembles A, B, opcode bytes, launches the result and waits for transmit completion.
module uart_alu_bridge #(
    parameter int DATA_BITS    = 8,
    parameter int OP_BITS      = 6,
    parameter int ERR_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_BITS-1:0]    rx_data,
    input  logic                    rx_done,
    input  logic                    rx_error,
    input  logic [DATA_BITS-1:0]    alu_result,
    input  logic                    tx_done,
    output logic [DATA_BITS-1:0]    alu_a,
    output logic [DATA_BITS-1:0]    alu_b,
    output logic [OP_BITS-1:0]      alu_op,
    output logic [DATA_BITS-1:0]    tx_data,
    output logic                    tx_start,
    output logic                    busy,
    output logic                    overrun,
    output logic [ERR_CNT_BITS-1:0] err_count
);

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_done_q, tx_done_q;
    logic                    rx_ev, tx_ev;
    logic [DATA_BITS-1:0]    alu_a_q, alu_a_d;
    logic [DATA_BITS-1:0]    alu_b_q, alu_b_d;
    logic [OP_BITS-1:0]      alu_op_q, alu_op_d;
    logic [DATA_BITS-1:0]    tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic                    overrun_q, overrun_d;
    logic [ERR_CNT_BITS-1:0] err_count_q, err_count_d;

    // A level held high on either done flag counts as a single event.
    assign rx_ev = rx_done & ~rx_done_q;
    assign tx_ev = tx_done & ~tx_done_q;

    // State, edge-detect and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_A;
            rx_done_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rx_done_q   <= rx_done;
            tx_done_q   <= tx_done;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            overrun_q   <= overrun_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic; any parity error restarts command assembly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A: begin
                if (rx_ev) state_d = rx_error ? ST_WAIT_A : ST_WAIT_B;
                else       state_d = state_q;
            end
            ST_WAIT_B: begin
                if (rx_ev) state_d = rx_error ? ST_WAIT_A : ST_WAIT_OP;
                else       state_d = state_q;
            end
            ST_WAIT_OP: begin
                if (rx_ev) state_d = rx_error ? ST_WAIT_A : ST_SEND;
                else       state_d = state_q;
            end
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (tx_ev) state_d = ST_WAIT_A;
                else       state_d = state_q;
            end
            default:    state_d = ST_WAIT_A;
        endcase
    end

    // Output/datapath next values; bytes arriving while busy are dropped and flagged.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        overrun_d   = overrun_q;
        err_count_d = err_count_q;
        case (state_q)
            ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP: begin
                if (rx_ev && rx_error) begin
                    if (err_count_q != {ERR_CNT_BITS{1'b1}}) begin
                        err_count_d = err_count_q + {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else if (rx_ev) begin
                    if (state_q == ST_WAIT_A)      alu_a_d  = rx_data;
                    else if (state_q == ST_WAIT_B) alu_b_d  = rx_data;
                    else                           alu_op_d = rx_data[OP_BITS-1:0];
                end else begin
                    err_count_d = err_count_q;
                end
            end
            ST_SEND: begin
                tx_data_d  = alu_result;
                tx_start_d = 1'b1;
                if (rx_ev) overrun_d = 1'b1;
                else       overrun_d = overrun_q;
            end
            ST_WAIT_TX: begin
                if (rx_ev) overrun_d = 1'b1;
                else       overrun_d = overrun_q;
            end
            default: begin
                tx_start_d = 1'b0;
            end
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign overrun   = overrun_q;
    assign err_count = err_count_q;
    assign busy      = (state_q == ST_SEND) || (state_q == ST_WAIT_TX);

endmodule
